// File: rtl/rps_pkg.sv
// Shared types and constants for the best-of-N stone/paper/scissors match
// controller: move encodings, judge verdicts, FSM states and ASCII result codes.
package rps_pkg;

  typedef enum logic [1:0] {
    STONE    = 2'b00,
    PAPER    = 2'b01,
    SCISSORS = 2'b10,
    BAD_MOVE = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    TIE,
    P1,
    P2,
    INVALID
  } winner_t;

  typedef enum logic [1:0] {
    WAIT,
    RESOLVE,
    OVER
  } state_t;

  localparam logic [7:0] ASCII_T   = 8'd84;
  localparam logic [7:0] ASCII_1   = 8'd49;
  localparam logic [7:0] ASCII_2   = 8'd50;
  localparam logic [7:0] ASCII_Q   = 8'd63;
  localparam logic [7:0] ASCII_A   = 8'd65;
  localparam logic [7:0] ASCII_B   = 8'd66;
  localparam logic [7:0] ASCII_NUL = 8'd0;

endpackage

// File: rtl/tt_um_rps_match_if.sv
// Tiny Tapeout user-module pin bundle; the harness side drives inputs as
// master, the match controller consumes them as slave.
interface tt_um_rps_match_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/rps_judge.sv
// Combinational single-round judge: the only place the win table lives.
module rps_judge
  import rps_pkg::*;
(
  input  move_t   move_a,
  input  move_t   move_b,
  output winner_t winner
);

  always_comb begin
    winner = INVALID;
    if (move_a != BAD_MOVE && move_b != BAD_MOVE) begin
      if (move_a == move_b)
        winner = TIE;
      else if ((move_a == PAPER    && move_b == STONE)    ||
               (move_a == SCISSORS && move_b == PAPER)    ||
               (move_a == STONE    && move_b == SCISSORS))
        winner = P1;
      else
        winner = P2;
    end
  end

endmodule

// File: rtl/tt_um_rps_match.sv
// Match controller: synchronizes pins, detects commit/new-match edges, latches
// moves, judges rounds and keeps scores until one player reaches ROUNDS_TO_WIN.
module tt_um_rps_match
  import rps_pkg::*;
#(
  parameter int unsigned ROUNDS_TO_WIN = 3
) (
  input logic              clk,
  input logic              rst_n,
  tt_um_rps_match_if.slave bus
);

  localparam logic [3:0] WIN_SCORE = 4'(ROUNDS_TO_WIN);

  logic [6:0] sync1, sync2;
  logic [2:0] prev_strobe;
  logic [2:0] rise;
  logic       p1_commit, p2_commit, new_match;

  state_t     state, state_nx;
  move_t      mv1, mv1_nx, mv2, mv2_nx;
  logic       pend1, pend1_nx, pend2, pend2_nx;
  logic [3:0] score1, score1_nx, score2, score2_nx;
  logic [7:0] result, result_nx;
  logic [3:0] score1_inc, score2_inc;
  winner_t    winner;

  logic unused;
  assign unused = ^{bus.ui_in[7], bus.uio_in};

  // The synchronizer and edge flops ignore ena, so edges seen while the block
  // is disabled are consumed and lost rather than replayed later.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which a shift chain depends on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      prev_strobe <= '0;
    end else begin
      sync1       <= bus.ui_in[6:0];
      sync2       <= sync1;
      prev_strobe <= sync2[6:4];
    end
  end

  assign rise      = sync2[6:4] & ~prev_strobe;
  assign p1_commit = rise[0];
  assign p2_commit = rise[1];
  assign new_match = rise[2];

  rps_judge u_judge (
    .move_a (mv1),
    .move_b (mv2),
    .winner (winner)
  );

  assign score1_inc = score1 + 4'd1;
  assign score2_inc = score2 + 4'd1;

  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nx  = state;
    mv1_nx    = mv1;
    mv2_nx    = mv2;
    pend1_nx  = pend1;
    pend2_nx  = pend2;
    score1_nx = score1;
    score2_nx = score2;
    result_nx = result;

    if (new_match) begin
      state_nx  = WAIT;
      pend1_nx  = 1'b0;
      pend2_nx  = 1'b0;
      score1_nx = '0;
      score2_nx = '0;
      result_nx = ASCII_NUL;
    end else begin
      case (state)
        WAIT: begin
          if (p1_commit && !pend1) begin
            pend1_nx = 1'b1;
            mv1_nx   = move_t'(sync2[1:0]);
          end
          if (p2_commit && !pend2) begin
            pend2_nx = 1'b1;
            mv2_nx   = move_t'(sync2[3:2]);
          end
          if (pend1_nx && pend2_nx) state_nx = RESOLVE;
        end
        RESOLVE: begin
          pend1_nx = 1'b0;
          pend2_nx = 1'b0;
          state_nx = WAIT;
          case (winner)
            TIE: result_nx = ASCII_T;
            P1: begin
              score1_nx = score1_inc;
              result_nx = ASCII_1;
              if (score1_inc == WIN_SCORE) begin
                state_nx  = OVER;
                result_nx = ASCII_A;
              end
            end
            P2: begin
              score2_nx = score2_inc;
              result_nx = ASCII_2;
              if (score2_inc == WIN_SCORE) begin
                state_nx  = OVER;
                result_nx = ASCII_B;
              end
            end
            default: result_nx = ASCII_Q;
          endcase
        end
        OVER:    state_nx = OVER;
        default: state_nx = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT;
      mv1    <= STONE;
      mv2    <= STONE;
      pend1  <= 1'b0;
      pend2  <= 1'b0;
      score1 <= '0;
      score2 <= '0;
      result <= ASCII_NUL;
    end else if (bus.ena) begin
      state  <= state_nx;
      mv1    <= mv1_nx;
      mv2    <= mv2_nx;
      pend1  <= pend1_nx;
      pend2  <= pend2_nx;
      score1 <= score1_nx;
      score2 <= score2_nx;
      result <= result_nx;
    end
  end

  assign bus.uo_out  = result;
  assign bus.uio_out = {score2, score1};
  assign bus.uio_oe  = 8'hFF;

endmodule

// File: doc/tt_um_rps_match.md
# tt_um_rps_match

Best-of-N stone/paper/scissors match controller: the sequential successor to the combinational single-round judge. Each player commits a move with a strobe; the block latches both moves, judges the round, keeps per-player scores and declares a match winner after `ROUNDS_TO_WIN` round wins. It sits at the Tiny Tapeout user-module boundary: moves and strobes on `ui_in`, ASCII result on `uo_out`, scores on `uio_out`.

## Interface
- `ROUNDS_TO_WIN`, default 3: round wins needed to take the match; legal range 1..15.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: high = block active; low freezes FSM, latches and scores.
- `ui_in` in 8: [1:0] P1 move, [3:2] P2 move (00 stone, 01 paper, 10 scissors, 11 invalid), [4] P1 commit, [5] P2 commit, [6] new-match, [7] unused.
- `uo_out` out 8: ASCII result code, registered.
- `uio_in` in 8: unused.
- `uio_out` out 8: [3:0] P1 score, [7:4] P2 score, registered.
- `uio_oe` out 8: constant 8'hFF.

## Operation
- `ui_in[6:0]` passes through a 2-flop synchronizer. A third flop on bits 4..6 gives rising-edge detection. All decisions use synchronized values only.
- FSM states:
  - WAIT: collecting commits.
  - RESOLVE: one cycle.
  - OVER: match decided.
- WAIT behaviour:
  - A commit edge from a player with no pending commit latches that player's synchronized move and sets their pending flag.
  - Further commits from an already-pending player are ignored; the first commit locks the move.
  - When both flags are set (including the same cycle), go to RESOLVE.
- RESOLVE:
  - Judge the latched moves and clear both pending flags.
  - Tie: `uo_out`='T'(84). P1 wins: '1'(49), P1 score +1. P2 wins: '2'(50), P2 score +1. Either move 11: '?'(63), no score change.
  - If the incremented score equals `ROUNDS_TO_WIN`, go to OVER and set `uo_out`='A'(65) for P1 or 'B'(66) for P2. Otherwise return to WAIT.
- OVER: commits are ignored; `uo_out` and the scores hold.
- New-match edge, in any state: clear scores, pending flags and `uo_out` (0x00), and go to WAIT. It has priority over a simultaneous commit edge, and that commit is dropped.
- Scores are 4-bit unsigned and never exceed `ROUNDS_TO_WIN`, so there is no wrap.
- `uo_out` holds the last result until the next RESOLVE or new-match.
- `ena` low:
  - No state, flag, score or output changes.
  - The synchronizer and edge flops keep running, so edges occurring while `ena` is low are lost.

## Timing
- Reset values: `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0xFF, state WAIT, flags clear, synchronizers 0.
- Latency (E = clock edge at which a pin change is first sampled):
  - Synchronized at E+1.
  - Edge detected in the cycle after E+1; move latched at E+2.
  - If the other player is already pending, RESOLVE runs in the cycle after E+2, and `uo_out`/`uio_out` update at E+3.
- Moves must be stable from one cycle before the commit rises until the latch edge.
- Commit and new-match must be high for at least 1 cycle and low for at least 1 cycle between events.
- Asynchronous reset mid-round discards pending moves and scores immediately.

## Structure
- Package `rps_pkg`:
  - Move encodings.
  - `winner_t` enum: TIE, P1, P2, INVALID.
  - `state_t` enum: WAIT, RESOLVE, OVER.
  - ASCII constants: T, 1, 2, ?, A, B.
- Sub-module `rps_judge`: combinational; two 2-bit moves in, `winner_t` out. It is the only copy of the win table.
- Top level holds the synchronizer, edge detect, FSM, move latches and score counters.

## Test plan
- Reset, then P1 commits paper (01), P2 commits stone (00) → `uo_out`=49, `uio_out`=0x01 at E+3 of the later commit.
- Both players commit scissors on the same cycle → `uo_out`=84, scores unchanged.
- P1 commits 11, P2 commits stone → `uo_out`=63, scores unchanged. Then P1 re-commits stone before P2 → a new round resolves.
- With `ROUNDS_TO_WIN`=3, P2 wins 3 rounds with a tie in between → `uo_out`=66, `uio_out`=0x30. Further commits give no change. New-match → `uo_out`=0x00, `uio_out`=0x00.
- P1 commits twice (stone, then paper) before P2 commits scissors → judged with stone, `uo_out`=49.
- `ena` low while both commit → nothing changes. Assert `rst_n` low with P1 pending → all outputs 0 immediately, and a later single P2 commit does not resolve.
